// File: rtl/burst_rr_mux.sv
// burst_rr_mux: packet-granular round-robin mux sharing one valid/ready channel
// between NUM_REQ requesters. A winner holds the channel until its last beat.
// Optional feature: define BURST_RR_MUX_LEN_CHECK_EN to cut packets at MAX_BEATS
// beats and flag the cut beat on err_o.
module burst_rr_mux #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    output logic                        out_last_o,
    output logic [$clog2(NUM_REQ)-1:0]  out_idx_o,
    input  logic                        out_ready_i,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic               err_q, err_d;

    logic [IDX_W-1:0]   cand_c;
    logic [IDX_W-1:0]   win_c;
    logic               win_vld_c;
    logic [IDX_W-1:0]   sel_c;
    logic [DATA_W-1:0]  sel_data_c;
    logic               sel_last_c;
    logic               can_acc_c;
    logic               xfer_c;
    logic               len_err_c;
    logic               eff_last_c;

`ifdef BURST_RR_MUX_LEN_CHECK_EN
    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_max_beats;
    assign unused_max_beats = ^MAX_BEATS;
`endif

    // Round-robin search starting just past the last packet winner; nearest offset wins.
    always_comb begin
        win_c     = ptr_q;
        win_vld_c = 1'b0;
        cand_c    = '0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            cand_c = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (req_valid_i[cand_c]) begin
                win_c     = cand_c;
                win_vld_c = 1'b1;
            end
        end
    end

    // Grant, transfer detection, FSM next state and output-slice next values.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        err_d       = err_q;
        req_ready_o = '0;
        sel_data_c  = '0;
        sel_last_c  = 1'b0;
        len_err_c   = 1'b0;
`ifdef BURST_RR_MUX_LEN_CHECK_EN
        cnt_d       = cnt_q;
`endif

        can_acc_c = !out_valid_q || out_ready_i;
        sel_c     = (state_q == LOCKED) ? gnt_q : win_c;

        if (!flush_i && can_acc_c && ((state_q == LOCKED) || win_vld_c)) begin
            req_ready_o[sel_c] = 1'b1;
        end
        xfer_c = |(req_ready_o & req_valid_i);

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (sel_c == IDX_W'(k)) begin
                sel_data_c = req_data_i[k*DATA_W +: DATA_W];
                sel_last_c = req_last_i[k];
            end
        end

`ifdef BURST_RR_MUX_LEN_CHECK_EN
        len_err_c = xfer_c && !sel_last_c && (cnt_q == CNT_W'(MAX_BEATS - 1));
`endif
        eff_last_c = sel_last_c || len_err_c;

        if (flush_i) begin
            state_d     = IDLE;
            ptr_d       = IDX_W'(NUM_REQ - 1);
            gnt_d       = '0;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
`ifdef BURST_RR_MUX_LEN_CHECK_EN
            cnt_d       = '0;
`endif
        end else if (xfer_c) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_c;
            out_last_d  = eff_last_c;
            out_idx_d   = sel_c;
            err_d       = len_err_c;
`ifdef BURST_RR_MUX_LEN_CHECK_EN
            cnt_d       = eff_last_c ? '0 : cnt_q + CNT_W'(1);
`endif
            if (eff_last_c) begin
                state_d = IDLE;
                ptr_d   = sel_c;
            end else begin
                state_d = LOCKED;
                gnt_d   = sel_c;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
            err_d       = 1'b0;
        end
    end

    // FSM state, priority pointer and locked requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Output register slice.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            err_q       <= err_d;
        end
    end

`ifdef BURST_RR_MUX_LEN_CHECK_EN
    // Beats transferred in the current packet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_idx_o   = out_idx_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q == LOCKED) || out_valid_q;

endmodule

// File: tb/tb_burst_rr_mux.sv
// Directed bench for burst_rr_mux (NUM_REQ=4, DATA_W=32, MAX_BEATS=4).
// Follows BURST_RR_MUX_LEN_CHECK_EN to pick length-check expectations.
module tb_burst_rr_mux;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic [3:0]    req_valid_i = '0;
    logic [127:0]  req_data_i;
    logic [3:0]    req_last_i = '0;
    logic [3:0]    req_ready_o;
    logic          out_valid_o;
    logic [31:0]   out_data_o;
    logic          out_last_o;
    logic [1:0]    out_idx_o;
    logic          out_ready_i = 1'b0;
    logic          busy_o;
    logic          err_o;

    logic [31:0]   d [4];
    int            n_err = 0;
    int            n_checks = 0;

    assign req_data_i = {d[3], d[2], d[1], d[0]};

    burst_rr_mux #(.NUM_REQ(4), .DATA_W(32), .MAX_BEATS(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_idx_o   (out_idx_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       flush;
        logic [3:0] valid;
        logic [3:0] last;
        logic       ordy;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_idx;
        logic       e_last;
        logic       e_busy;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic exp_last;
        logic exp_err;

        for (int k = 0; k < 4; k++) d[k] = '0;

        // Reset priority (0,1,2,3,0), burst lock on req 1, then idle.
        vecs[0] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 32'h000};
        vecs[1] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 32'h101};
        vecs[2] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 32'h202};
        vecs[3] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b1, 32'h303};
        vecs[4] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1, 32'h004};
        vecs[5] = '{1'b0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1, 32'h105};
        vecs[6] = '{1'b0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1, 32'h106};
        vecs[7] = '{1'b0, 4'b0111, 4'b0111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b1, 32'h107};
        vecs[8] = '{1'b0, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1, 32'h208};
        vecs[9] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0, 32'h208};

        // Reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst out_valid", 64'(out_valid_o), 64'd0);
        check("rst out_data", 64'(out_data_o), 64'd0);
        check("rst out_last", 64'(out_last_o), 64'd0);
        check("rst out_idx", 64'(out_idx_o), 64'd0);
        check("rst err", 64'(err_o), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst ready", 64'(req_ready_o), 64'd0);
        rst_ni = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            flush_i     = vecs[i].flush;
            req_valid_i = vecs[i].valid;
            req_last_i  = vecs[i].last;
            out_ready_i = vecs[i].ordy;
            for (int k = 0; k < 4; k++) d[k] = (32'(k) << 8) | 32'(i);
            #1;
            check($sformatf("vec%0d ready", i), 64'(req_ready_o), 64'(vecs[i].e_rdy));
            step();
            check($sformatf("vec%0d out_valid", i), 64'(out_valid_o), 64'(vecs[i].e_ov));
            check($sformatf("vec%0d out_idx", i), 64'(out_idx_o), 64'(vecs[i].e_idx));
            check($sformatf("vec%0d out_last", i), 64'(out_last_o), 64'(vecs[i].e_last));
            check($sformatf("vec%0d busy", i), 64'(busy_o), 64'(vecs[i].e_busy));
            check($sformatf("vec%0d out_data", i), 64'(out_data_o), 64'(vecs[i].e_data));
            check($sformatf("vec%0d err", i), 64'(err_o), 64'd0);
        end

        // Backpressure mid-burst from req 0 (pointer at 2)
        @(negedge clk_i);
        req_valid_i = 4'b0001;
        req_last_i  = 4'b0000;
        out_ready_i = 1'b1;
        d[0] = 32'hD0;
        #1;
        check("bp first ready", 64'(req_ready_o), 64'b0001);
        step();
        check("bp first data", 64'(out_data_o), 64'hD0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            out_ready_i = 1'b0;
            d[0] = 32'hD1;
            #1;
            check($sformatf("bp stall%0d ready", c), 64'(req_ready_o), 64'd0);
            step();
            check($sformatf("bp stall%0d data", c), 64'(out_data_o), 64'hD0);
            check($sformatf("bp stall%0d valid", c), 64'(out_valid_o), 64'd1);
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        #1;
        check("bp resume ready", 64'(req_ready_o), 64'b0001);
        step();
        check("bp resume data", 64'(out_data_o), 64'hD1);
        @(negedge clk_i);
        d[0] = 32'hD2;
        req_last_i = 4'b0001;
        step();
        check("bp last data", 64'(out_data_o), 64'hD2);
        check("bp last flag", 64'(out_last_o), 64'd1);
        @(negedge clk_i);
        req_valid_i = 4'b0000;
        req_last_i  = 4'b0000;
        step();
        check("bp drain valid", 64'(out_valid_o), 64'd0);

        // Flush while req 2 holds the lock with a pending output beat
        @(negedge clk_i);
        req_valid_i = 4'b0100;
        out_ready_i = 1'b0;
        d[2] = 32'hE0;
        #1;
        check("fl lock ready", 64'(req_ready_o), 64'b0100);
        step();
        check("fl lock valid", 64'(out_valid_o), 64'd1);
        check("fl lock idx", 64'(out_idx_o), 64'd2);
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        check("fl cycle ready", 64'(req_ready_o), 64'd0);
        step();
        check("fl after valid", 64'(out_valid_o), 64'd0);
        check("fl after busy", 64'(busy_o), 64'd0);
        @(negedge clk_i);
        flush_i     = 1'b0;
        req_valid_i = 4'b1001;
        req_last_i  = 4'b1001;
        out_ready_i = 1'b1;
        #1;
        check("fl winner ready", 64'(req_ready_o), 64'b0001);
        step();
        check("fl winner idx", 64'(out_idx_o), 64'd0);
        @(negedge clk_i);
        req_valid_i = 4'b0000;
        req_last_i  = 4'b0000;
        step();
        check("fl drain valid", 64'(out_valid_o), 64'd0);

        // 6-beat packet from req 3 against MAX_BEATS=4
        for (int b = 1; b <= 6; b++) begin
            @(negedge clk_i);
            req_valid_i = 4'b1000;
            req_last_i  = (b == 6) ? 4'b1000 : 4'b0000;
            d[3] = 32'h30 + 32'(b);
            #1;
            check($sformatf("len beat%0d ready", b), 64'(req_ready_o), 64'b1000);
            step();
`ifdef BURST_RR_MUX_LEN_CHECK_EN
            exp_last = (b == 4) || (b == 6);
            exp_err  = (b == 4);
`else
            exp_last = (b == 6);
            exp_err  = 1'b0;
`endif
            check($sformatf("len beat%0d valid", b), 64'(out_valid_o), 64'd1);
            check($sformatf("len beat%0d data", b), 64'(out_data_o), 64'h30 + 64'(b));
            check($sformatf("len beat%0d last", b), 64'(out_last_o), 64'(exp_last));
            check($sformatf("len beat%0d err", b), 64'(err_o), 64'(exp_err));
        end
        @(negedge clk_i);
        req_valid_i = 4'b0000;
        req_last_i  = 4'b0000;
        step();
        check("len drain valid", 64'(out_valid_o), 64'd0);
        check("len drain err", 64'(err_o), 64'd0);
        check("len drain busy", 64'(busy_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/burst_rr_mux.md
# burst_rr_mux

Packet-granular round-robin multiplexer that shares one valid/ready output channel between NUM_REQ requester streams. Once a requester wins, it keeps the channel until its last beat is accepted, so bursts are never interleaved. Round-robin priority then rotates past the winner. Sits in front of shared interconnect ports (memory controller, peripheral bus bridge) wherever several masters converge on one streaming sink.

## Interface
- NUM_REQ, default 4: number of requesters, must be >= 2.
- DATA_W, default 32: payload width per beat.
- MAX_BEATS, default 16: maximum beats per grant; used only with the length-check feature; must be >= 2.
- IDX_W is derived as $clog2(NUM_REQ); it is not overridable.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of state, priority pointer and output stage.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_data_i  in  NUM_REQ*DATA_W  payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- req_last_i  in  NUM_REQ  marks the final beat of a packet.
- req_ready_o  out  NUM_REQ  per-requester beat accept; at most one bit high.
- out_valid_o  out  1  output beat valid.
- out_data_o  out  DATA_W  output payload.
- out_last_o  out  1  output last-beat marker.
- out_idx_o  out  IDX_W  source requester of the output beat.
- out_ready_i  in  1  sink accept.
- busy_o  out  1  high when state is LOCKED or out_valid_o is high.
- err_o  out  1  length-violation flag, registered and aligned with the offending output beat.

## Operation
- **Output stage.** A single register slice holds out_valid_o, data, last and idx.
  - can_acc = !out_valid_o || out_ready_i.
  - An input beat transfers when req_valid_i[g] && req_ready_o[g].
- **FSM states.** IDLE and LOCKED. Registers are state_q, ptr_q (last packet winner) and gnt_q (locked requester).
- **IDLE.**
  - Winner g is the first k with req_valid_i[k] set, searching from ptr_q+1 upward and wrapping past NUM_REQ-1 to 0.
  - The search is combinational, in the same cycle.
  - req_ready_o[g] = can_acc; all other ready bits are 0.
  - When no request is valid, all ready bits are 0.
- **Transfer from IDLE.**
  - If req_last_i[g] is set: remain in IDLE and set ptr_q <= g.
  - Otherwise: go to LOCKED and set gnt_q <= g.
- **LOCKED.**
  - req_ready_o[gnt_q] = can_acc; all other ready bits are 0, regardless of their valid.
  - Transfer with last set: go to IDLE and set ptr_q <= gnt_q.
- **Dependency rule.** req_ready_o may depend on req_valid_i. Requesters must not make valid depend on ready.
- **Stalls.** When out_ready_i is low and out_valid_o is high, all ready bits are 0 and the output holds stable.
- **Pointer update.** ptr_q changes only on packet completion. Non-winning requests never alter it.
- **flush_i (synchronous).** In the flush cycle all req_ready_o are 0. On the next edge: state_q=IDLE, ptr_q=NUM_REQ-1, out_valid_o=0 (any pending beat is dropped), beat counter=0, err_o=0. Flush overrides any transfer.
- **Reset mid-packet.** Same effect as flush, applied asynchronously.

## Timing
- **Latency.** An input transfer at edge n makes the beat appear on out_* after edge n, i.e. one cycle.
- **Throughput.** One beat per cycle while out_ready_i stays high, including back-to-back packets from different requesters with no bubble.
- **Reset values.**
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_idx_o=0, err_o=0, busy_o=0.
  - ptr_q=NUM_REQ-1, so requester 0 has top priority after reset.
  - gnt_q=0.
- **Output hold.** out_data_o, out_last_o and out_idx_o change only when can_acc and a transfer occurs. out_valid_o falls after a sink accept with no new transfer.

## Configuration
- Macro: BURST_RR_MUX_LEN_CHECK_EN.
- **Defined.**
  - A beat counter, $clog2(MAX_BEATS+1) bits, counts transfers of the current packet and clears on completion or flush.
  - The check applies when the transferred beat is the MAX_BEATS-th and req_last_i is 0. That beat is forwarded with out_last_o=1 and err_o=1 in the same output slot.
  - The FSM then returns to IDLE with ptr_q <= winner.
  - The requester's remaining beats re-arbitrate as a new packet.
  - err_o clears when that beat is accepted, or when a new beat without error is loaded.
- **Undefined.** No counter is built, err_o is tied to 0, MAX_BEATS is ignored and packets are unbounded.

## Test plan
- **Reset priority.** After reset, req_valid_i=4'b1111 with single-beat packets and out_ready_i=1 -> out_idx_o sequence 0,1,2,3,0 on consecutive cycles, out_valid_o continuously high from cycle 1.
- **Burst lock.** Req 1 sends a 3-beat packet while req 0 and req 2 stay valid -> out_idx_o=1,1,1 then 2; req_ready_o[0] and req_ready_o[2] stay 0 during the lock.
- **Backpressure.** out_ready_i=0 for 5 cycles mid-burst -> all req_ready_o=0, out_data_o held constant; transfer resumes the cycle after out_ready_i=1 with no lost or duplicated beat.
- **Flush mid-packet.** Req 2 in LOCKED with out_valid_o=1 and flush_i pulsed -> next cycle out_valid_o=0, busy_o=0; req 0 and req 3 both valid -> req 0 wins.
- **Length check (macro defined, MAX_BEATS=4).** 6-beat packet from req 3 -> 4th output beat has out_last_o=1 and err_o=1; beats 5-6 follow as a new packet; err_o=0 on them.
- **Length check (macro undefined).** The same 6-beat packet -> single packet, out_last_o only on beat 6, err_o=0 throughout.
